// File: rtl/matrix_alloc_manager_if.sv
// Request/grant, commit, query and status signals of the matrix BRAM slot allocator.
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 8
`endif

interface matrix_alloc_manager_if #(
  parameter int unsigned ADDR_WIDTH = `BRAM_ADDR_WIDTH
);
  logic                  alloc_req;
  logic                  alloc_valid;
  logic [3:0]            alloc_slot;
  logic [ADDR_WIDTH-1:0] alloc_addr;
  logic                  alloc_err;
  logic                  alloc_abort;
  logic                  commit_req;
  logic [3:0]            commit_slot;
  logic [3:0]            commit_m;
  logic [3:0]            commit_n;
  logic                  commit_err;
  logic                  clear_all;
  logic [3:0]            query_slot;
  logic                  query_valid;
  logic [3:0]            query_m;
  logic [3:0]            query_n;
  logic [ADDR_WIDTH-1:0] query_addr;
  logic [4:0]            used_count;
  logic                  evicted;

  modport master (
    output alloc_req, alloc_abort, commit_req, commit_slot, commit_m, commit_n,
           clear_all, query_slot,
    input  alloc_valid, alloc_slot, alloc_addr, alloc_err, commit_err,
           query_valid, query_m, query_n, query_addr, used_count, evicted
  );

  modport slave (
    input  alloc_req, alloc_abort, commit_req, commit_slot, commit_m, commit_n,
           clear_all, query_slot,
    output alloc_valid, alloc_slot, alloc_addr, alloc_err, commit_err,
           query_valid, query_m, query_n, query_addr, used_count, evicted
  );
endinterface

// File: rtl/matrix_alloc_manager.sv
// Slot allocator and metadata tracker for the matrix BRAM.
// Build option: define ALLOC_EVICT_EN to recycle the oldest committed slot when storage is full.
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 8
`endif

module matrix_alloc_manager #(
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned SLOT_SIZE  = 25,
  parameter int unsigned ADDR_WIDTH = `BRAM_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_alloc_manager_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
`ifdef ALLOC_EVICT_EN
  localparam bit EVICT_EN = 1'b1;
`else
  localparam bit EVICT_EN = 1'b0;
`endif

  typedef enum logic {ST_IDLE = 1'b0, ST_PENDING = 1'b1} state_e;
  state_e state_q, state_d;

  logic                  armed_q, armed_d;
  logic [3:0]            pend_q, pend_d;
  logic [NUM_SLOTS-1:0]  valid_q, valid_d;
  logic [3:0]            m_q [NUM_SLOTS];
  logic [3:0]            m_d [NUM_SLOTS];
  logic [3:0]            n_q [NUM_SLOTS];
  logic [3:0]            n_d [NUM_SLOTS];
  logic [4:0]            used_q, used_d;
  logic                  alloc_valid_q, alloc_valid_d;
  logic [3:0]            alloc_slot_q, alloc_slot_d;
  logic [ADDR_WIDTH-1:0] alloc_addr_q, alloc_addr_d;
  logic                  alloc_err_q, alloc_err_d;
  logic                  commit_err_q, commit_err_d;
  logic                  query_valid_q, query_valid_d;
  logic [3:0]            query_m_q, query_m_d;
  logic [3:0]            query_n_q, query_n_d;
  logic [ADDR_WIDTH-1:0] query_addr_q, query_addr_d;

  logic       free_found_c;
  logic [3:0] free_idx_c;
  logic [3:0] victim_c;
  logic [3:0] grant_slot_c;
  logic       req_c, grant_c, evict_c, full_err_c;
  logic       commit_hit_c, commit_err_c, abort_c;

  // Request decode: lowest free slot, grant/evict/full decisions, commit validation.
  always_comb begin
    free_found_c = 1'b0;
    free_idx_c   = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      if (!valid_q[IDX_W'(i)] && !free_found_c) begin
        free_found_c = 1'b1;
        free_idx_c   = 4'(i);
      end
    end
    req_c        = (state_q == ST_IDLE) && bus.alloc_req && armed_q && !bus.clear_all;
    grant_c      = req_c && (free_found_c || EVICT_EN);
    evict_c      = req_c && !free_found_c && EVICT_EN;
    full_err_c   = req_c && !free_found_c && !EVICT_EN;
    grant_slot_c = free_found_c ? free_idx_c : victim_c;
    commit_hit_c = (state_q == ST_PENDING) && bus.commit_req && !bus.clear_all &&
                   (bus.commit_slot == pend_q) && (bus.commit_m != '0) && (bus.commit_n != '0);
    commit_err_c = bus.commit_req && !bus.clear_all && !commit_hit_c;
    abort_c      = (state_q == ST_PENDING) && bus.alloc_abort && !bus.commit_req && !bus.clear_all;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear_all)                 state_d = ST_IDLE;
    else if (grant_c)                  state_d = ST_PENDING;
    else if (commit_hit_c || abort_c)  state_d = ST_IDLE;
  end

  always_comb begin
    armed_d       = armed_q;
    pend_d        = pend_q;
    valid_d       = valid_q;
    m_d           = m_q;
    n_d           = n_q;
    used_d        = used_q;
    alloc_valid_d = grant_c;
    alloc_slot_d  = alloc_slot_q;
    alloc_addr_d  = alloc_addr_q;
    alloc_err_d   = full_err_c;
    commit_err_d  = commit_err_c;
    query_valid_d = 1'b0;
    query_m_d     = '0;
    query_n_d     = '0;
    query_addr_d  = '0;

    if (bus.clear_all) begin
      valid_d = '0;
      used_d  = '0;
    end else begin
      if (!bus.alloc_req) armed_d = 1'b1;
      else if (req_c)     armed_d = 1'b0;
      if (grant_c) begin
        pend_d       = grant_slot_c;
        alloc_slot_d = grant_slot_c;
        alloc_addr_d = ADDR_WIDTH'(grant_slot_c) * ADDR_WIDTH'(SLOT_SIZE);
      end
      if (evict_c) begin
        valid_d[IDX_W'(victim_c)] = 1'b0;
        used_d                    = used_q - 5'd1;
      end
      if (commit_hit_c) begin
        valid_d[IDX_W'(pend_q)] = 1'b1;
        m_d[IDX_W'(pend_q)]     = bus.commit_m;
        n_d[IDX_W'(pend_q)]     = bus.commit_n;
        used_d                  = used_q + 5'd1;
      end
    end

    // Out-of-range or uncommitted slots report all zeros.
    if ((5'(bus.query_slot) < 5'(NUM_SLOTS)) && valid_q[IDX_W'(bus.query_slot)]) begin
      query_valid_d = 1'b1;
      query_m_d     = m_q[IDX_W'(bus.query_slot)];
      query_n_d     = n_q[IDX_W'(bus.query_slot)];
      query_addr_d  = ADDR_WIDTH'(bus.query_slot) * ADDR_WIDTH'(SLOT_SIZE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q       <= 1'b1;
      pend_q        <= '0;
      valid_q       <= '0;
      used_q        <= '0;
      alloc_valid_q <= 1'b0;
      alloc_slot_q  <= '0;
      alloc_addr_q  <= '0;
      alloc_err_q   <= 1'b0;
      commit_err_q  <= 1'b0;
      query_valid_q <= 1'b0;
      query_m_q     <= '0;
      query_n_q     <= '0;
      query_addr_q  <= '0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        m_q[IDX_W'(i)] <= '0;
        n_q[IDX_W'(i)] <= '0;
      end
    end else begin
      armed_q       <= armed_d;
      pend_q        <= pend_d;
      valid_q       <= valid_d;
      used_q        <= used_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_slot_q  <= alloc_slot_d;
      alloc_addr_q  <= alloc_addr_d;
      alloc_err_q   <= alloc_err_d;
      commit_err_q  <= commit_err_d;
      query_valid_q <= query_valid_d;
      query_m_q     <= query_m_d;
      query_n_q     <= query_n_d;
      query_addr_q  <= query_addr_d;
      m_q           <= m_d;
      n_q           <= n_d;
    end
  end

`ifdef ALLOC_EVICT_EN
  // Commit-order FIFO: head is the oldest committed slot, the eviction victim.
  logic [3:0]       fifo_q [NUM_SLOTS];
  logic [3:0]       fifo_d [NUM_SLOTS];
  logic [IDX_W-1:0] head_q, head_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [4:0]       tail_sum_c;
  logic             evicted_q, evicted_d;

  assign victim_c = fifo_q[head_q];

  always_comb begin
    fifo_d     = fifo_q;
    head_d     = head_q;
    cnt_d      = cnt_q;
    evicted_d  = evict_c;
    tail_sum_c = 5'(head_q) + cnt_q;
    if (tail_sum_c >= 5'(NUM_SLOTS)) tail_sum_c = tail_sum_c - 5'(NUM_SLOTS);
    if (bus.clear_all) begin
      head_d = '0;
      cnt_d  = '0;
    end else if (evict_c) begin
      head_d = (head_q == IDX_W'(NUM_SLOTS - 1)) ? '0 : head_q + IDX_W'(1);
      cnt_d  = cnt_q - 5'd1;
    end else if (commit_hit_c) begin
      fifo_d[IDX_W'(tail_sum_c)] = pend_q;
      cnt_d                      = cnt_q + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q    <= '0;
      cnt_q     <= '0;
      evicted_q <= 1'b0;
      for (int i = 0; i < int'(NUM_SLOTS); i++) fifo_q[IDX_W'(i)] <= '0;
    end else begin
      head_q    <= head_d;
      cnt_q     <= cnt_d;
      evicted_q <= evicted_d;
      fifo_q    <= fifo_d;
    end
  end

  assign bus.evicted = evicted_q;
`else
  assign victim_c    = '0;
  assign bus.evicted = 1'b0;
`endif

  assign bus.alloc_valid = alloc_valid_q;
  assign bus.alloc_slot  = alloc_slot_q;
  assign bus.alloc_addr  = alloc_addr_q;
  assign bus.alloc_err   = alloc_err_q;
  assign bus.commit_err  = commit_err_q;
  assign bus.query_valid = query_valid_q;
  assign bus.query_m     = query_m_q;
  assign bus.query_n     = query_n_q;
  assign bus.query_addr  = query_addr_q;
  assign bus.used_count  = used_q;
endmodule
